// File: rtl/pipeline_if_id_queue.sv
// -----------------------------------------------------------------------------
// pipeline_if_id_queue
//
// In-order fetch queue that sits between the fetch stage (instruction memory
// and PC logic) and the decode stage. It holds up to DEPTH fetched
// instructions together with their PC and PC+4.
//
// Fetch side (valid/ready handshake):
//   valid_F  in   fetch presents a valid instruction this cycle
//   instr_F  in   instruction from instruction memory
//   PC_F     in   PC of instr_F
//   PCP4_F   in   PC + 4 of instr_F
//   ready_F  out  queue can accept an entry (count != DEPTH)
//
// Decode side (stall):
//   stall_D  in   decode cannot consume the head this cycle
//   valid_D  out  head entry is valid (count != 0)
//   instr_D  out  head instruction, or NOP when the queue is empty
//   PC_D     out  head PC, or 0 when the queue is empty
//   PCP4_D   out  head PC + 4, or 0 when the queue is empty
//
// Control / status:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   flush    in   synchronous discard of all entries (branch/jump redirect)
//   count    out  current occupancy
// -----------------------------------------------------------------------------
module pipeline_if_id_queue #(
   parameter int               WIDTH = 32,
   parameter int               DEPTH = 2,
   parameter logic [WIDTH-1:0] NOP   = WIDTH'(32'h0000_0013)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_F,
   input  logic [WIDTH-1:0]             instr_F,
   input  logic [WIDTH-1:0]             PC_F,
   input  logic [WIDTH-1:0]             PCP4_F,
   output logic                         ready_F,
   input  logic                         stall_D,
   input  logic                         flush,
   output logic                         valid_D,
   output logic [WIDTH-1:0]             instr_D,
   output logic [WIDTH-1:0]             PC_D,
   output logic [WIDTH-1:0]             PCP4_D,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

   typedef struct packed {
      logic [WIDTH-1:0] instr;
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] pcp4;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;
   logic            push, pop;
   entry_t          head;

   // DEPTH need not be a power of two, so wrap by explicit compare.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // ready_F depends on occupancy only; no combinational path from stall_D.
   assign ready_F = (count_q != FULL_COUNT);
   assign valid_D = (count_q != '0);
   assign push    = valid_F && ready_F;
   assign pop     = valid_D && !stall_D;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         // Redirect wins over any push/pop requested in the same cycle.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: storage is included in the asynchronous reset so the queue comes
   // up with known contents; flush only rewinds pointers and leaves data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push && !flush) begin
            mem_q[wr_ptr_q] <= '{instr: instr_F, pc: PC_F, pcp4: PCP4_F};
         end
      end
   end

   // Read path is a plain mux of the head slot, masked to NOP/0 when empty.
   assign head    = mem_q[rd_ptr_q];
   assign instr_D = valid_D ? head.instr : NOP;
   assign PC_D    = valid_D ? head.pc    : '0;
   assign PCP4_D  = valid_D ? head.pcp4  : '0;
   assign count   = count_q;

endmodule

// File: tb/tb_pipeline_if_id_queue.sv
// -----------------------------------------------------------------------------
// Bench for pipeline_if_id_queue. Two instances share all stimulus: dut_a
// (DEPTH = 2) and dut_b (DEPTH = 3, exercises non power-of-two wrap). Each has
// its own FIFO scoreboard queue; expected entries are pushed when an accepted
// fetch is driven and popped/compared when decode consumes the head.
// -----------------------------------------------------------------------------
module tb_pipeline_if_id_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcp4;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_F;
   logic [31:0] instr_F, PC_F, PCP4_F;
   logic        stall_D;
   logic        flush;

   logic        ready_f_a, valid_d_a;
   logic [31:0] instr_d_a, pc_d_a, pcp4_d_a;
   logic [1:0]  count_a;

   logic        ready_f_b, valid_d_b;
   logic [31:0] instr_d_b, pc_d_b, pcp4_d_b;
   logic [1:0]  count_b;

   int total = 0;
   int bad   = 0;

   entry_t sb_a[$];
   entry_t sb_b[$];

   always #5 clk = ~clk;

   pipeline_if_id_queue #(.WIDTH(32), .DEPTH(2), .NOP(NOP)) dut_a (
      .clk(clk), .rst_n(rst_n), .valid_F(valid_F), .instr_F(instr_F),
      .PC_F(PC_F), .PCP4_F(PCP4_F), .ready_F(ready_f_a), .stall_D(stall_D),
      .flush(flush), .valid_D(valid_d_a), .instr_D(instr_d_a), .PC_D(pc_d_a),
      .PCP4_D(pcp4_d_a), .count(count_a)
   );

   pipeline_if_id_queue #(.WIDTH(32), .DEPTH(3), .NOP(NOP)) dut_b (
      .clk(clk), .rst_n(rst_n), .valid_F(valid_F), .instr_F(instr_F),
      .PC_F(PC_F), .PCP4_F(PCP4_F), .ready_F(ready_f_b), .stall_D(stall_D),
      .flush(flush), .valid_D(valid_d_b), .instr_D(instr_d_b), .PC_D(pc_d_b),
      .PCP4_D(pcp4_d_b), .count(count_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare one DUT against its scoreboard: occupancy, flags and head entry.
   task automatic check_dut(input string tag, input bit which);
      entry_t      exp_head, obs_head;
      int unsigned n, depth;
      logic        valid, ready;
      logic [31:0] cnt;
      if (!which) begin
         n = sb_a.size(); depth = 2;
         exp_head = (n != 0) ? sb_a[0] : '{instr: NOP, pc: '0, pcp4: '0};
         obs_head = '{instr: instr_d_a, pc: pc_d_a, pcp4: pcp4_d_a};
         valid = valid_d_a; ready = ready_f_a; cnt = 32'(count_a);
      end else begin
         n = sb_b.size(); depth = 3;
         exp_head = (n != 0) ? sb_b[0] : '{instr: NOP, pc: '0, pcp4: '0};
         obs_head = '{instr: instr_d_b, pc: pc_d_b, pcp4: pcp4_d_b};
         valid = valid_d_b; ready = ready_f_b; cnt = 32'(count_b);
      end
      check({tag, ".count"},   cnt,                   n);
      check({tag, ".valid_D"}, 32'(valid),            32'(n != 0));
      check({tag, ".ready_F"}, 32'(ready),            32'(n != depth));
      check({tag, ".instr_D"}, obs_head.instr,        exp_head.instr);
      check({tag, ".PC_D"},    obs_head.pc,           exp_head.pc);
      check({tag, ".PCP4_D"},  obs_head.pcp4,         exp_head.pcp4);
   endtask

   // Check both DUTs, advance both scoreboards, then cross one rising edge.
   task automatic tick();
      entry_t cur;
      bit     push_a, pop_a, push_b, pop_b;
      if (!rst_n) begin
         sb_a.delete();
         sb_b.delete();
      end
      check_dut("dut_a", 1'b0);
      check_dut("dut_b", 1'b1);
      if (rst_n) begin
         cur = '{instr: instr_F, pc: PC_F, pcp4: PCP4_F};
         if (flush) begin
            sb_a.delete();
            sb_b.delete();
         end else begin
            push_a = valid_F && (sb_a.size() != 2);
            pop_a  = (sb_a.size() != 0) && !stall_D;
            push_b = valid_F && (sb_b.size() != 3);
            pop_b  = (sb_b.size() != 0) && !stall_D;
            if (pop_a)  void'(sb_a.pop_front());
            if (push_a) sb_a.push_back(cur);
            if (pop_b)  void'(sb_b.pop_front());
            if (push_b) sb_b.push_back(cur);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      valid_F = v;
      instr_F = instr;
      PC_F    = pc;
      PCP4_F  = pc + 32'd4;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      stall_D = 1'b0;
      flush   = 1'b0;
      drive(1'b0, '0, '0);
      #1;

      // Reset held for two cycles, then idle.
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle.instr_D", instr_d_a, NOP);

      // Streaming with no stall: occupancy stays at one.
      drive(1'b1, 32'h0050_0093, 32'h0);
      tick();
      check("stream0.count", 32'(count_a), 32'd1);
      check("stream0.instr", instr_d_a, 32'h0050_0093);
      drive(1'b1, 32'h00a0_0113, 32'h4);
      tick();
      check("stream1.pcp4", pcp4_d_a, 32'h8);
      drive(1'b1, 32'h0020_81b3, 32'h8);
      tick();
      check("stream2.pc", pc_d_a, 32'h8);
      check("stream2.count", 32'(count_a), 32'd1);
      drive(1'b0, '0, '0);
      repeat (2) tick();

      // Back-pressure: decode stalled, fetch pushes three entries.
      stall_D = 1'b1;
      drive(1'b1, 32'h1111_0001, 32'h10);
      tick();
      drive(1'b1, 32'h1111_0002, 32'h14);
      tick();
      drive(1'b1, 32'h1111_0003, 32'h18);
      check("bp.full_count", 32'(count_a), 32'd2);
      check("bp.ready_low", 32'(ready_f_a), 32'd0);
      tick();
      check("bp.held_count", 32'(count_a), 32'd2);
      check("bp.head_held", pc_d_a, 32'h10);
      // Full with stall released: pop only, no push.
      stall_D = 1'b0;
      tick();
      check("full_pop.count", 32'(count_a), 32'd1);
      check("full_pop.head", pc_d_a, 32'h14);
      // Count one: simultaneous push and pop.
      tick();
      check("pushpop.count", 32'(count_a), 32'd1);
      check("pushpop.head", pc_d_a, 32'h18);
      drive(1'b0, '0, '0);
      repeat (3) tick();

      // Flush with two entries queued and a fetch pending.
      stall_D = 1'b1;
      drive(1'b1, 32'h2222_0001, 32'h30);
      tick();
      drive(1'b1, 32'h2222_0002, 32'h34);
      tick();
      drive(1'b1, 32'h2222_0003, 32'h20);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      check("flush.count", 32'(count_a), 32'd0);
      check("flush.instr", instr_d_a, NOP);
      check("flush.count_b", 32'(count_b), 32'd0);
      stall_D = 1'b0;
      drive(1'b1, 32'h2222_0004, 32'h40);
      tick();
      check("after_flush.pc", pc_d_a, 32'h40);
      drive(1'b0, '0, '0);
      repeat (2) tick();

      // Seven-entry stream: dut_b pointers wrap twice.
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 32'h3333_0000 + 32'(i), 32'h100 + 32'(4 * i));
         tick();
      end
      drive(1'b0, '0, '0);
      tick();

      // Fill partly, then drop reset between clock edges.
      stall_D = 1'b1;
      drive(1'b1, 32'h4444_0001, 32'h200);
      tick();
      drive(1'b1, 32'h4444_0002, 32'h204);
      tick();
      check("pre_rst.count_b", 32'(count_b), 32'd2);
      drive(1'b0, '0, '0);
      stall_D = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst.valid_b", 32'(valid_d_b), 32'd0);
      check("async_rst.count_b", 32'(count_b), 32'd0);
      check("async_rst.instr_b", instr_d_b, NOP);
      check("async_rst.valid_a", 32'(valid_d_a), 32'd0);
      sb_a.delete();
      sb_b.delete();
      @(posedge clk);
      #1;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_if_id_queue.md
Name: pipeline_if_id_queue

Overview:
- Parametrised successor to the fetch/decode pipeline register.
- Replaces the single stall-hold register with a DEPTH-entry in-order fetch queue, using a valid/ready handshake on the fetch side and a stall on the decode side.
- Adds asynchronous reset, synchronous flush for branch redirect, and NOP bubble injection when empty.
- Sits between instruction memory/PC logic and the decode stage.

Parameters:
- WIDTH, 32, width of instruction, PC and PC+4 fields.
- DEPTH, 2, number of queue entries; legal range 2..16, any integer (not restricted to powers of two).
- NOP, 32'h00000013, instruction driven on instr_D when the queue is empty (RISC-V addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_F  in  1  fetch presents a valid instruction this cycle.
- instr_F  in  WIDTH  instruction from instruction memory port RD.
- PC_F  in  WIDTH  PC of instr_F.
- PCP4_F  in  WIDTH  PC plus 4 of instr_F.
- ready_F  out  1  queue can accept; equals count != DEPTH.
- stall_D  in  1  decode cannot consume the head this cycle.
- flush  in  1  discard all queued entries (branch/jump redirect).
- valid_D  out  1  head entry is valid; equals count != 0.
- instr_D  out  WIDTH  head instruction, or NOP when valid_D = 0.
- PC_D  out  WIDTH  head PC, or 0 when valid_D = 0.
- PCP4_D  out  WIDTH  head PC+4, or 0 when valid_D = 0.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = count = 0; storage cleared to 0.
  - Outputs during and after reset: valid_D = 0, instr_D = NOP, PC_D = 0, PCP4_D = 0, ready_F = 1, count = 0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Enqueue: push = valid_F && ready_F. On the rising edge, {instr_F, PC_F, PCP4_F} are written at wr_ptr and wr_ptr advances.
- Dequeue: pop = valid_D && !stall_D. On the rising edge, rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 advances to 0 (explicit compare, not power-of-two masking).
- Occupancy update: count += push - pop. When push and pop occur together, count is unchanged.
- Full queue: ready_F is low and depends only on count. There is no combinational path from stall_D to ready_F, so a full queue does not accept a push even in a cycle where it pops.
- Empty queue: no pop can occur. Fall-through from fetch to decode in the same cycle is not supported; see Latency.
- Latency: an entry pushed at edge k appears on the _D outputs after edge k, provided the queue was empty or all earlier entries have drained. This matches the one-cycle timing of the previous register.
- Read path: the _D outputs are a combinational mux of storage[rd_ptr] gated by valid_D. There is no extra register stage.
- Stall: while stall_D = 1, the head entry and the _D outputs hold. Enqueue continues until the queue is full.
- Flush (synchronous, highest priority):
  - At the edge where flush = 1: wr_ptr = rd_ptr = count = 0.
  - A push or pop requested in the same cycle is discarded.
  - Storage contents need not be cleared.
  - In the next cycle valid_D = 0 and instr_D = NOP.
  - ready_F is unaffected in the flush cycle itself.
- Handshake rules:
  - Fetch holds instr_F, PC_F and PCP4_F stable while valid_F && !ready_F.
  - Fetch may deassert valid_F at any time.
  - The queue never drops an accepted entry except on flush or reset.
- Ordering: strict FIFO order. No reordering, no duplication.
- Widths: count width is $clog2(DEPTH+1); pointer width is $clog2(DEPTH).

Test Plan:
- Reset then idle:
  - rst_n low for 2 cycles, release, valid_F = 0.
  - Expect valid_D = 0, instr_D = 32'h00000013, PC_D = 0, ready_F = 1, count = 0 throughout.
- Streaming, DEPTH = 2, stall_D = 0:
  - Push 0x00500093 @ PC 0x0, 0x00a00113 @ PC 0x4, 0x002081b3 @ PC 0x8 on consecutive cycles.
  - Each appears on the _D outputs one edge later with PCP4_D = PC+4.
  - count stays at 1.
- Back-pressure:
  - stall_D = 1, push 3 entries (PC 0x10, 0x14, 0x18).
  - After 2 edges count = 2, ready_F = 0, and the 0x18 entry is held at fetch.
  - Release stall_D: decode sees PC 0x10, 0x14, 0x18 in order with no loss or duplication.
- Simultaneous push and pop at count = 1:
  - count stays 1 and the head advances to the new entry.
  - At count = 2 with stall_D = 0 and valid_F = 1: no push (ready_F = 0), one pop, count becomes 1.
- Flush:
  - With count = 2 and valid_F = 1 (PC 0x20), assert flush for 1 cycle.
  - Next cycle count = 0, valid_D = 0, instr_D = NOP, and PC 0x20 is not enqueued.
  - A push of PC 0x40 next cycle appears one edge later.
- Asynchronous reset mid-stream plus pointer wrap, DEPTH = 3:
  - Stream 7 entries so the pointers wrap twice; verify order is preserved.
  - Then drop rst_n between clock edges: valid_D falls immediately and count = 0 before the next edge.
